// File: rtl/param_dp_ram.sv
// Simple dual-port RAM with an automatic zero-fill after reset and a write-first read bypass.
// Optional build macro RAM_OUT_REG_EN adds a second output register (read latency 2).
module param_dp_ram #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] din,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              busy
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] READY = 1'b1;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic              ready;
  logic              wr_en, rd_en;
  logic [DATA_W-1:0] rd_data_d;
  logic [DATA_W-1:0] dout1_q;
  logic              vld1_q;

  assign ready = (state_q == READY);
  assign busy  = ~ready;
  assign wr_en = ready & we;
  assign rd_en = ready & re;

  // Pointer rolls back to 0 naturally as it leaves the last word.
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    if (state_q == CLEAR) begin
      clr_ptr_d = clr_ptr_q + 1'b1;
      if (clr_ptr_q == {ADDR_W{1'b1}}) state_d = READY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (!ready)     mem[clr_ptr_q] <= '0;
      else if (wr_en) mem[waddr]     <= din;
    end
  end

  // Same-address write/read returns the incoming data.
  assign rd_data_d = (wr_en && (waddr == raddr)) ? din : mem[raddr];

  always_ff @(posedge clk) begin
    if (rst) begin
      dout1_q <= '0;
      vld1_q  <= 1'b0;
    end else begin
      vld1_q <= rd_en;
      if (rd_en) dout1_q <= rd_data_d;
    end
  end

`ifdef RAM_OUT_REG_EN
  logic [DATA_W-1:0] dout2_q;
  logic              vld2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      dout2_q <= '0;
      vld2_q  <= 1'b0;
    end else begin
      vld2_q <= vld1_q;
      if (vld1_q) dout2_q <= dout1_q;
    end
  end

  assign dout       = dout2_q;
  assign dout_valid = vld2_q;
`else
  assign dout       = dout1_q;
  assign dout_valid = vld1_q;
`endif

endmodule

// File: tb/tb_param_dp_ram.sv
// Scoreboard bench for param_dp_ram: reads push expected data/due-cycle, the monitor pops on dout_valid.
module tb_param_dp_ram;
  localparam int DATA_W = 4;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 2 ** ADDR_W;
`ifdef RAM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic              clk = 1'b0;
  logic              rst, we, re;
  logic [ADDR_W-1:0] waddr, raddr;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout;
  logic              dout_valid, busy;

  param_dp_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .din(din),
    .re(re), .raddr(raddr), .dout(dout), .dout_valid(dout_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] d;
    int                due;
  } exp_t;

  exp_t              q[$];
  logic [DATA_W-1:0] model [DEPTH];
  logic [DATA_W-1:0] hold;
  int                cyc = 0;
  int                total = 0;
  int                bad = 0;
  bit                armed = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (armed) begin
      if (dout_valid === 1'b1) begin
        if (q.size() == 0) chk("spurious_vld", dout_valid, 1'b0);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("rd_data", dout, e.d);
          chk("rd_lat", cyc, e.due);
          hold = e.d;
        end
      end else begin
        chk("hold", dout, hold);
        if (q.size() != 0 && q[0].due < cyc) begin
          chk("missed_vld", dout_valid, 1'b1);
          void'(q.pop_front());
        end
      end
    end
  end

  task automatic op(input logic w, input int wa, input logic [DATA_W-1:0] d,
                    input logic r, input int ra);
    exp_t e;
    @(negedge clk); #1;
    we = w; waddr = ADDR_W'(wa); din = d;
    re = r; raddr = ADDR_W'(ra);
    if (r) begin
      e.d   = (w && wa == ra) ? d : model[ra];
      e.due = cyc + LAT;
      q.push_back(e);
    end
    if (w) model[wa] = d;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk); #1;
      we = 1'b0; re = 1'b0;
    end
  endtask

  // Drives one reset edge, checks the reset state, then releases rst.
  task automatic hit_rst();
    @(negedge clk); #1;
    rst = 1'b1; we = 1'b0; re = 1'b0;
    q.delete();
    hold = '0;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    @(negedge clk); #1;
    armed = 1'b1;
    chk("rst_busy", busy, 1'b1);
    chk("rst_dout", dout, '0);
    chk("rst_vld", dout_valid, 1'b0);
    rst = 1'b0;
  endtask

  task automatic count_busy(input int exp_n);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk); #1;
    end
    chk("busy_len", n, exp_n);
  endtask

  initial begin
    rst = 1'b0; we = 1'b0; re = 1'b0;
    waddr = '0; raddr = '0; din = '0;
    hold = '0;
    repeat (2) @(negedge clk);

    hit_rst();
    count_busy(DEPTH);
    op(0, 0, 4'h0, 1, 7);
    idle(3);

    op(1, 3, 4'b1010, 0, 0);
    op(1, 1, 4'b1001, 0, 0);
    op(0, 0, 4'h0, 1, 3);
    op(0, 0, 4'h0, 1, 1);
    idle(3);

    op(1, 2, 4'b1100, 1, 2);
    op(1, 4, 4'b0110, 1, 1);
    op(0, 0, 4'h0, 1, 4);
    op(0, 0, 4'h0, 1, 2);
    idle(3);

    // Reset mid-clear must restart the fill and wipe earlier writes.
    op(1, 5, 4'b1111, 0, 0);
    op(0, 0, 4'h0, 1, 5);
    idle(4);
    hit_rst();
    repeat (10) begin @(negedge clk); #1; end
    hit_rst();
    count_busy(DEPTH);
    op(0, 0, 4'h0, 1, 5);
    idle(3);

    // Traffic while busy must be ignored: no valid, no memory change.
    hit_rst();
    repeat (20) begin @(negedge clk); #1; end
    we = 1'b1; re = 1'b1; waddr = 9; raddr = 9; din = 4'hF;
    @(negedge clk); #1;
    we = 1'b0; re = 1'b0;
    count_busy(DEPTH - 21);
    op(0, 0, 4'h0, 1, 9);
    idle(3);

    for (int i = 0; i < 200; i++)
      op(1'($urandom_range(0, 1)), $urandom_range(0, DEPTH - 1), 4'($urandom),
         1'($urandom_range(0, 1)), $urandom_range(0, DEPTH - 1));
    idle(5);
    chk("drain", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/param_dp_ram.md
PARAM_DP_RAM -- requirements
Module: param_dp_ram

Interface
REQ-001 Parameter DATA_W, default 4, data word width in bits (1..64).
REQ-002 Parameter ADDR_W, default 5, address width; DEPTH = 2**ADDR_W words.
REQ-003 Port clk  input  1  single clock; all logic on rising edge.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port we  input  1  write enable.
REQ-006 Port waddr  input  ADDR_W  write address.
REQ-007 Port din  input  DATA_W  write data.
REQ-008 Port re  input  1  read enable.
REQ-009 Port raddr  input  ADDR_W  read address.
REQ-010 Port dout  output  DATA_W  registered read data.
REQ-011 Port dout_valid  output  1  high for one cycle per accepted read, aligned with dout.
REQ-012 Port busy  output  1  high while the post-reset clear sequence runs; we/re ignored.

Function
REQ-013 The block SHALL implement a two-state FSM, CLEAR and READY, with state held in a register.
REQ-014 In CLEAR, each cycle SHALL write 0 to mem[clr_ptr] and increment clr_ptr; after writing DEPTH-1, it SHALL go to READY and deassert busy. CLEAR lasts exactly DEPTH cycles.
REQ-015 In CLEAR, we and re SHALL be ignored: no write, dout unchanged, dout_valid=0.
REQ-016 In READY, we=1 at an edge SHALL write din to mem[waddr].
REQ-017 In READY, re=1 at edge N SHALL load dout with mem[raddr] and assert dout_valid after edge N (latency 1).
REQ-018 With re=0, dout SHALL hold its last value and dout_valid SHALL be 0.
REQ-019 If we=1, re=1 and waddr==raddr in the same cycle, dout SHALL return din (write-first bypass).
REQ-020 If we=1, re=1 and waddr!=raddr, the write and read SHALL complete independently in that cycle.
REQ-021 Back-to-back reads SHALL be supported every cycle with no bubbles.
REQ-022 Address arithmetic SHALL wrap modulo DEPTH, so clr_ptr rolls from DEPTH-1 to 0 on exit from CLEAR.

Reset
REQ-023 rst=1 at an edge SHALL set state=CLEAR, clr_ptr=0, busy=1, dout=0 and dout_valid=0.
REQ-024 rst asserted mid-CLEAR SHALL restart the clear at address 0; rst in READY SHALL discard any in-flight read.
REQ-025 rst SHALL take priority over we and re in the same cycle.

Configuration
REQ-026 With RAM_OUT_REG_EN defined, a second output register SHALL be added: read latency becomes 2, and dout_valid is delayed to match; rst clears both stages.
REQ-027 With RAM_OUT_REG_EN undefined, read latency SHALL be 1 per REQ-017. Bypass per REQ-019 SHALL apply in both builds.

Verification (DATA_W=4, ADDR_W=5)
REQ-028 Release rst; check busy=1 for exactly 32 cycles, then 0; then read addr 7 -> dout=0000 with dout_valid=1.
REQ-029 Write 1010 to addr 3 and 1001 to addr 1; read addr 3 then addr 1 on consecutive cycles -> dout=1010 then 1001, with dout_valid high two cycles.
REQ-030 Set we=1, re=1, waddr=raddr=2, din=1100 -> dout=1100 next cycle; write 0110 to addr 4 while reading addr 1 -> dout=1001.
REQ-031 Assert rst at clear cycle 10 -> busy stays high 32 cycles after release; a prior write of 1111 to addr 5 reads back 0000.
REQ-032 Pulse we=1, re=1 while busy=1 -> no dout_valid, no memory change; repeat the suite with RAM_OUT_REG_EN defined -> every dout appears one cycle later.
